mem_access_sched: RTL and testbench

- Single-port scheduler for the image/filter `memory` block.
- Arbitrates two burst-read requesters (image loader, filter loader) onto the one combinational read port with round-robin fairness.
- Sequences the memory's bulk image write-back strobe, so reads never see a half-written image region.
- Sits between the convolution datapath loaders and the `memory` instance.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_access_sched_if.sv | 40 ++++
 rtl/mem_access_sched_rr_arb2.sv | 28 ++
 rtl/mem_access_sched.sv | 154 +++++++++++++++
 tb/tb_mem_access_sched.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory access scheduler.
// Widths here are the defaults; instances may override them.
package mem_pkg;

   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 32;
   localparam int MAX_MEM_SIZE = 128;
   localparam int LEN_W        = 8;

   localparam int REQ_IMG = 0;
   localparam int REQ_FLT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      WB    = 2'd2
   } state_e;

endpackage

// File: rtl/mem_access_sched_if.sv
// Loader, write-back and memory-side signals of the scheduler.
// slave: the scheduler; master: loaders plus memory.
interface mem_access_sched_if #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int LEN_W  = mem_pkg::LEN_W
);

   logic [1:0]        req;
   logic [ADDR_W-1:0] base0;
   logic [ADDR_W-1:0] base1;
   logic [LEN_W-1:0]  len0;
   logic [LEN_W-1:0]  len1;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [DATA_W-1:0] rdata;
   logic              rlast;
   logic              wb_req;
   logic              wb_ack;
   logic [ADDR_W-1:0] mem_rd_adr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_write_en;
   logic              busy;
   logic              err;

   modport slave (
      input  req, base0, base1, len0, len1,
      input  wb_req, mem_rd_data,
      output gnt, rvalid, rdata, rlast, wb_ack,
      output mem_rd_adr, mem_write_en, busy, err
   );

   modport master (
      output req, base0, base1, len0, len1,
      output wb_req, mem_rd_data,
      input  gnt, rvalid, rdata, rlast, wb_ack,
      input  mem_rd_adr, mem_write_en, busy, err
   );

endinterface

// File: rtl/mem_access_sched_rr_arb2.sv
// Two-way round-robin arbiter; on advance the
// requester that did not win takes priority.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

   logic prio_q;

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = prio_q ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else if (adv_i) begin
         prio_q <= gnt_o[0];
      end
   end

endmodule

// File: rtl/mem_access_sched.sv
// Burst-read / write-back scheduler for the single-port image memory.
// Define MEM_ACCESS_SCHED_BOUNDS_CHK_EN to reject bursts past MAX_MEM_SIZE.
module mem_access_sched #(
   parameter int ADDR_W       = mem_pkg::ADDR_W,
   parameter int DATA_W       = mem_pkg::DATA_W,
   parameter int MAX_MEM_SIZE = mem_pkg::MAX_MEM_SIZE,
   parameter int LEN_W        = mem_pkg::LEN_W
) (
   input logic               clk,
   input logic               rst_n,
   mem_access_sched_if.slave bus
);

   import mem_pkg::*;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_BURST = BURST;
   localparam logic [1:0] S_WB    = WB;
   localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_MEM_SIZE);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              own_q, own_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rlast_q, rlast_d;
   logic              wen_q, wen_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   logic [1:0]        elig, win;
   logic              adv, oob;
   logic [ADDR_W-1:0] sel_base, adr_nxt;
   logic [LEN_W-1:0]  sel_len;
   logic [ADDR_W:0]   adr_inc;

   // zero-length requests never compete
   assign elig = bus.req & {|bus.len1, |bus.len0};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (elig),
      .adv_i (adv),
      .gnt_o (win)
   );

   assign sel_base = win[REQ_FLT] ? bus.base1 : bus.base0;
   assign sel_len  = win[REQ_FLT] ? bus.len1  : bus.len0;
   assign adv      = (state_q == S_IDLE) && !bus.wb_req && |win;

   assign adr_inc = {1'b0, adr_q} + (ADDR_W+1)'(1);
   assign adr_nxt = (adr_inc >= MAX_W) ? ADDR_W'(adr_inc - MAX_W)
                                       : adr_inc[ADDR_W-1:0];

`ifdef MEM_ACCESS_SCHED_BOUNDS_CHK_EN
   localparam int SW = ADDR_W + LEN_W;
   logic [SW-1:0] span;
   assign span = SW'(sel_base) + SW'(sel_len);
   assign oob  = span > SW'(MAX_MEM_SIZE);
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      cnt_d    = cnt_q;
      own_d    = own_q;
      gnt_d    = '0;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      rlast_d  = 1'b0;
      wen_d    = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.wb_req) begin
               state_d = S_WB;
               wen_d   = 1'b1;
            end else if (adv) begin
               gnt_d = win;
               if (oob) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_BURST;
                  adr_d   = sel_base;
                  cnt_d   = sel_len;
                  own_d   = win[REQ_FLT];
               end
            end
         end
         S_BURST: begin
            rvalid_d[own_q] = 1'b1;
            rdata_d         = bus.mem_rd_data;
            if (cnt_q == LEN_W'(1)) begin
               rlast_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
               adr_d = adr_nxt;
            end
         end
         S_WB: begin
            ack_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // write strobe comes straight from a flop so the memory sees no glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         adr_q    <= '0;
         cnt_q    <= '0;
         own_q    <= 1'b0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         rlast_q  <= 1'b0;
         wen_q    <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         cnt_q    <= cnt_d;
         own_q    <= own_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rlast_q  <= rlast_d;
         wen_q    <= wen_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.rvalid       = rvalid_q;
   assign bus.rdata        = rdata_q;
   assign bus.rlast        = rlast_q;
   assign bus.wb_ack       = ack_q;
   assign bus.mem_rd_adr   = adr_q;
   assign bus.mem_write_en = wen_q;
   assign bus.busy         = state_q != S_IDLE;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_mem_access_sched.sv
// Randomized bench for mem_access_sched with a transaction-level model.
// Honours MEM_ACCESS_SCHED_BOUNDS_CHK_EN when predicting rejects.
module tb_mem_access_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mem_access_sched_if #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) bus ();

   mem_access_sched #(
      .ADDR_W(8), .DATA_W(32), .MAX_MEM_SIZE(128), .LEN_W(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [128];
   always_comb bus.mem_rd_data = mem[bus.mem_rd_adr[6:0]];

   int checks = 0;
   int errors = 0;
   int ptr = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit oob_f(int base, int len);
`ifdef MEM_ACCESS_SCHED_BOUNDS_CHK_EN
      return base + len > 128;
`else
      return 1'b0;
`endif
   endfunction

   task automatic serve(int who, int base, int len);
      logic [1:0] oh;
      bit rej;
      oh  = 2'(1 << who);
      rej = oob_f(base, len);
      step();
      check("gnt", bus.gnt, oh);
      check("err", bus.err, rej);
      check("gnt_busy", bus.busy, !rej);
      check("gnt_rvalid", bus.rvalid, 0);
      ptr = 1 - who;
      bus.req[who] = 1'b0;
      if (!rej) begin
         check("adr0", bus.mem_rd_adr, base);
         for (int k = 1; k <= len; k++) begin
            step();
            check("rvalid", bus.rvalid, oh);
            check("rdata", bus.rdata, mem[(base + k - 1) % 128]);
            check("rlast", bus.rlast, k == len);
            check("busy", bus.busy, k != len);
            if (k < len) check("adr", bus.mem_rd_adr, (base + k) % 128);
         end
      end
   endtask

   task automatic do_wb();
      step();
      check("wen", bus.mem_write_en, 1);
      check("wb_busy", bus.busy, 1);
      check("wb_gnt", bus.gnt, 0);
      step();
      check("wb_ack", bus.wb_ack, 1);
      check("wen_off", bus.mem_write_en, 0);
      bus.wb_req = 1'b0;
   endtask

   task automatic round(bit wb, bit r0, bit r1,
                        int b0, int l0, int b1, int l1);
      int bs[2];
      int ls[2];
      int f;
      bs[0] = b0; bs[1] = b1;
      ls[0] = l0; ls[1] = l1;
      bus.base0  = 8'(b0);
      bus.len0   = 8'(l0);
      bus.base1  = 8'(b1);
      bus.len1   = 8'(l1);
      bus.req    = {r1, r0};
      bus.wb_req = wb;
      if (wb) do_wb();
      if (r0 && r1) begin
         f = ptr;
         serve(f, bs[f], ls[f]);
         serve(1 - f, bs[1 - f], ls[1 - f]);
      end else if (r0) begin
         serve(0, b0, l0);
      end else if (r1) begin
         serve(1, b1, l1);
      end else if (!wb) begin
         step();
         check("idle_gnt", bus.gnt, 0);
         check("idle_busy", bus.busy, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      bus.req    = '0;
      bus.base0  = '0;
      bus.base1  = '0;
      bus.len0   = '0;
      bus.len1   = '0;
      bus.wb_req = 1'b0;
      #23;
      check("rst_out", {bus.gnt, bus.rvalid, bus.rdata, bus.rlast,
                        bus.wb_ack, bus.mem_rd_adr, bus.mem_write_en,
                        bus.busy, bus.err}, 0);
      rst_n = 1'b1;
      step();

      round(0, 1, 0, 16, 4, 0, 0);
      round(0, 1, 1, 30, 2, 50, 2);
      round(0, 1, 1, 60, 2, 70, 2);
      round(1, 1, 0, 5, 3, 0, 0);
      round(0, 1, 0, 126, 4, 0, 0);
      round(1, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         round(($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom),
               $urandom_range(0, 127), $urandom_range(1, 9),
               $urandom_range(0, 127), $urandom_range(1, 9));
      end

      bus.len1 = '0;
      bus.req  = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step();
         check("len0_gnt", bus.gnt, 0);
         check("len0_busy", bus.busy, 0);
      end
      bus.req = '0;
      step();

      bus.base0 = 8'd40;
      bus.len0  = 8'd8;
      bus.req   = 2'b01;
      step();
      check("mid_gnt", bus.gnt, 2'b01);
      bus.req = '0;
      step();
      step();
      check("mid_beat2", bus.rvalid, 2'b01);
      rst_n = 1'b0;
      #1;
      check("rst_async", {bus.gnt, bus.rvalid, bus.rdata, bus.rlast,
                          bus.wb_ack, bus.mem_rd_adr, bus.mem_write_en,
                          bus.busy, bus.err}, 0);
      ptr = 0;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("no_stray", {bus.rvalid, bus.rlast, bus.busy}, 0);
      end
      round(0, 1, 0, 100, 5, 0, 0);
      round(0, 1, 1, 127, 3, 10, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
